random_point_gen: RTL and testbench

RANDOM_POINT_GEN -- requirements
Module: random_point_gen

---
 rtl/random_point_gen_pkg.sv | 22 ++
 rtl/random_point_gen_if.sv | 29 ++
 rtl/random_point_gen_range_sampler.sv | 24 ++
 rtl/random_point_gen.sv | 126 ++++++++++++
 tb/tb_random_point_gen.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/random_point_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : random_point_pkg
//  Purpose  : Shared types and widths for the random point generator:
//             FSM state encoding, axis widths and try-counter width.
//  Revision : 1.0  initial release
// ============================================================================
package random_point_pkg;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int TRY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAMPLE_X = 2'd1,
        ST_SAMPLE_Y = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/random_point_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : random_point_gen_if
//  Purpose  : Request/response bundle between a point consumer (master) and
//             the random point generator (slave), including the LFSR feed.
//  Revision : 1.0  initial release
// ============================================================================
interface random_point_gen_if;
    import random_point_pkg::*;

    logic [15:0]    rand_in;
    logic           req_in;
    logic           ready_in;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic           valid_out;
    logic           busy_out;

    modport master (
        output rand_in, req_in, ready_in,
        input  x_out, y_out, valid_out, busy_out
    );

    modport slave (
        input  rand_in, req_in, ready_in,
        output x_out, y_out, valid_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/random_point_gen_range_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : range_sampler
//  Purpose  : Combinational accept test (candidate < bound) and fold value
//             (candidate - bound, wrapping at the axis width) for one axis.
//  Revision : 1.0  initial release
// ============================================================================
module range_sampler #(
    parameter int W     = 11,
    parameter int BOUND = 1280
) (
    input  wire logic [W-1:0] i_cand,
    output logic              o_accept,
    output logic [W-1:0]      o_fold
);

    // One extra bit so a bound equal to 2**W is representable.
    localparam logic [W:0] c_BOUND = (W+1)'(BOUND);

    assign o_accept = ({1'b0, i_cand} < c_BOUND);
    assign o_fold   = i_cand - c_BOUND[W-1:0];

endmodule
`default_nettype wire

// File: rtl/random_point_gen.sv
`default_nettype none
// ============================================================================
//  Module   : random_point_gen
//  Purpose  : Rejection-sampling generator of (x, y) points inside an
//             H_MAX x V_MAX window; after MAX_TRIES rejections on an axis
//             the rejected candidate is folded back into range.
//  Revision : 1.0  initial release
// ============================================================================
module random_point_gen
    import random_point_pkg::*;
#(
    parameter int H_MAX     = 1280,
    parameter int V_MAX     = 720,
    parameter int MAX_TRIES = 8
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    random_point_gen_if.slave  bus
);

    localparam logic [TRY_W-1:0] c_LAST_TRY = TRY_W'(MAX_TRIES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TRY_W-1:0] r_tries;
    logic [TRY_W-1:0] w_tries_nxt;
    logic [X_W-1:0]   r_x;
    logic [X_W-1:0]   w_x_nxt;
    logic [Y_W-1:0]   r_y;
    logic [Y_W-1:0]   w_y_nxt;

    logic             w_x_accept;
    logic [X_W-1:0]   w_x_fold;
    logic             w_y_accept;
    logic [Y_W-1:0]   w_y_fold;
    logic             w_unused_rand;

    // Upper LFSR bits are not needed by either axis.
    assign w_unused_rand = ^bus.rand_in[15:X_W];

    range_sampler #(.W(X_W), .BOUND(H_MAX)) u_x_sampler (
        .i_cand   (bus.rand_in[X_W-1:0]),
        .o_accept (w_x_accept),
        .o_fold   (w_x_fold)
    );

    range_sampler #(.W(Y_W), .BOUND(V_MAX)) u_y_sampler (
        .i_cand   (bus.rand_in[Y_W-1:0]),
        .o_accept (w_y_accept),
        .o_fold   (w_y_fold)
    );

    // State, try counter and coordinate registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_tries <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tries <= w_tries_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // Next-state logic: sample each axis until accepted or the fold fallback fires.
    always_comb begin
        w_state_nxt = r_state;
        w_tries_nxt = r_tries;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_in) begin
                    w_state_nxt = ST_SAMPLE_X;
                    w_tries_nxt = '0;
                end
            end
            ST_SAMPLE_X: begin
                if (w_x_accept) begin
                    w_x_nxt     = bus.rand_in[X_W-1:0];
                    w_tries_nxt = '0;
                    w_state_nxt = ST_SAMPLE_Y;
                end else if (r_tries == c_LAST_TRY) begin
                    w_x_nxt     = w_x_fold;
                    w_tries_nxt = '0;
                    w_state_nxt = ST_SAMPLE_Y;
                end else begin
                    w_tries_nxt = r_tries + TRY_W'(1);
                end
            end
            ST_SAMPLE_Y: begin
                if (w_y_accept) begin
                    w_y_nxt     = bus.rand_in[Y_W-1:0];
                    w_tries_nxt = '0;
                    w_state_nxt = ST_DONE;
                end else if (r_tries == c_LAST_TRY) begin
                    w_y_nxt     = w_y_fold;
                    w_tries_nxt = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_tries_nxt = r_tries + TRY_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.ready_in) begin
                    w_tries_nxt = '0;
                    w_state_nxt = bus.req_in ? ST_SAMPLE_X : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tries_nxt = '0;
            end
        endcase
    end

    assign bus.x_out     = r_x;
    assign bus.y_out     = r_y;
    assign bus.valid_out = (r_state == ST_DONE);
    assign bus.busy_out  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_random_point_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_point_gen
//  Purpose  : Directed self-checking bench for random_point_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_random_point_gen;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    random_point_gen_if bus();

    random_point_gen #(
        .H_MAX     (1280),
        .V_MAX     (720),
        .MAX_TRIES (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rnd;
        int          exp_x;
        int          exp_y;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse req with rand held at r; return the cycle at which valid first shows.
    task automatic request(input logic [15:0] r, output int lat);
        @(negedge clk);
        bus.rand_in = r;
        bus.req_in  = 1'b1;
        tick();
        lat = 1;
        @(negedge clk);
        bus.req_in = 1'b0;
        while (!bus.valid_out && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic acknowledge(input string name);
        @(negedge clk);
        bus.ready_in = 1'b1;
        tick();
        @(negedge clk);
        bus.ready_in = 1'b0;
        chk({name, "_valid_after_ack"}, int'(bus.valid_out), 0);
        chk({name, "_busy_after_ack"}, int'(bus.busy_out), 0);
    endtask

    initial begin
        int          lat;
        int          points;
        int          cycles;
        logic [15:0] lfsr;

        checks   = 0;
        failures = 0;
        rst          = 1'b1;
        bus.rand_in  = 16'h0000;
        bus.req_in   = 1'b0;
        bus.ready_in = 1'b0;

        vecs[0] = '{16'h0123,  291,  291,  3};
        vecs[1] = '{16'h07FF,  767,  303, 17};
        vecs[2] = '{16'h04FF, 1279,  255,  3};
        vecs[3] = '{16'h0500,    0,  256, 10};
        vecs[4] = '{16'h02D0,  720,    0, 10};
        vecs[5] = '{16'h02CF,  719,  719,  3};
        vecs[6] = '{16'hFFFF,  767,  303, 17};
        vecs[7] = '{16'h0000,    0,    0,  3};
        vecs[8] = '{16'h1ABC,  700,  700,  3};
        vecs[9] = '{16'h0600,  256,  512, 10};

        // Reset state
        tick();
        tick();
        chk("reset_x", int'(bus.x_out), 0);
        chk("reset_y", int'(bus.y_out), 0);
        chk("reset_valid", int'(bus.valid_out), 0);
        chk("reset_busy", int'(bus.busy_out), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(bus.busy_out), 0);

        // Table-driven points with rand held constant
        for (int i = 0; i < 10; i++) begin
            request(vecs[i].rnd, lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_x", i), int'(bus.x_out), vecs[i].exp_x);
            chk($sformatf("vec%0d_y", i), int'(bus.y_out), vecs[i].exp_y);
            chk($sformatf("vec%0d_busy", i), int'(bus.busy_out), 1);
            acknowledge($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_x_held_idle", i), int'(bus.x_out), vecs[i].exp_x);
        end

        // Hold in DONE with ready low while rand varies; req is ignored too
        request(16'h07FF, lat);
        chk("hold_latency", lat, 17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.rand_in = 16'($urandom);
            bus.req_in  = i[0];
            tick();
            chk($sformatf("hold%0d_x", i), int'(bus.x_out), 767);
            chk($sformatf("hold%0d_y", i), int'(bus.y_out), 303);
            chk($sformatf("hold%0d_valid", i), int'(bus.valid_out), 1);
        end
        @(negedge clk);
        bus.req_in = 1'b0;
        acknowledge("hold");

        // Back-to-back: ready and req together in DONE
        request(16'h0123, lat);
        chk("b2b_first_latency", lat, 3);
        @(negedge clk);
        bus.ready_in = 1'b1;
        bus.req_in   = 1'b1;
        bus.rand_in  = 16'h0045;
        tick();
        chk("b2b_c1_busy", int'(bus.busy_out), 1);
        chk("b2b_c1_valid", int'(bus.valid_out), 0);
        @(negedge clk);
        bus.ready_in = 1'b0;
        bus.req_in   = 1'b0;
        tick();
        chk("b2b_c2_busy", int'(bus.busy_out), 1);
        chk("b2b_c2_valid", int'(bus.valid_out), 0);
        tick();
        chk("b2b_c3_valid", int'(bus.valid_out), 1);
        chk("b2b_c3_x", int'(bus.x_out), 69);
        chk("b2b_c3_y", int'(bus.y_out), 69);
        acknowledge("b2b");

        // Reset while in SAMPLE_Y (x accepted, y rejected repeatedly)
        @(negedge clk);
        bus.rand_in = 16'h02D0;
        bus.req_in  = 1'b1;
        tick();
        @(negedge clk);
        bus.req_in = 1'b0;
        tick();
        tick();
        chk("rsty_pre_x", int'(bus.x_out), 720);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rsty_x", int'(bus.x_out), 0);
        chk("rsty_y", int'(bus.y_out), 0);
        chk("rsty_valid", int'(bus.valid_out), 0);
        chk("rsty_busy", int'(bus.busy_out), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk("rsty_stays_idle", int'(bus.busy_out), 0);

        // Reset while in DONE aborts delivery
        request(16'h0123, lat);
        chk("rstd_latency", lat, 3);
        @(negedge clk);
        rst = 1'b1;
        bus.ready_in = 1'b1;
        tick();
        chk("rstd_valid", int'(bus.valid_out), 0);
        chk("rstd_x", int'(bus.x_out), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_in = 1'b0;

        // Random stream from a live LFSR, continuous request and ready
        lfsr   = 16'hACE1;
        points = 0;
        cycles = 0;
        @(negedge clk);
        bus.req_in   = 1'b1;
        bus.ready_in = 1'b1;
        while (points < 10000 && cycles < 90000) begin
            @(negedge clk);
            lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            bus.rand_in = lfsr;
            tick();
            cycles++;
            if (bus.valid_out) begin
                points++;
                checks++;
                if (!(int'(bus.x_out) < 1280 && int'(bus.y_out) < 720)) begin
                    failures++;
                    $display("FAIL rand_bounds actual=(%0d,%0d) required=(<1280,<720)",
                             bus.x_out, bus.y_out);
                end
            end
        end
        chk("rand_point_count", points, 10000);
        @(negedge clk);
        bus.req_in   = 1'b0;
        bus.ready_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
